// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier: FSM states,
// operand/product widths, step count and partial-product placement.
package mult_pkg;

   localparam int OPND_W = 8;
   localparam int PROD_W = 16;
   localparam int NIB_W  = 4;
   localparam int STEPS  = 4;
   localparam int STEP_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Step k multiplies a nibble k[0] by b nibble k[1]; each high nibble adds 4 bits of weight.
   function automatic logic [PROD_W-1:0] place_partial(
      input logic [2*NIB_W-1:0] pp,
      input logic [STEP_W-1:0]  k
   );
      logic [1:0]        nib_sum;
      logic [PROD_W-1:0] wide;
      nib_sum = {1'b0, k[0]} + {1'b0, k[1]};
      wide    = {{(PROD_W-2*NIB_W){1'b0}}, pp};
      return wide << {nib_sum, 2'b00};
   endfunction

endpackage

// File: rtl/mult4x4_array.sv
// Combinational 4x4 unsigned array multiplier built from shifted AND rows,
// so no arithmetic multiplier operator is inferred.
module mult4x4_array
   import mult_pkg::*;
(
   input  logic [NIB_W-1:0]   a,
   input  logic [NIB_W-1:0]   b,
   output logic [2*NIB_W-1:0] p
);

   logic [2*NIB_W-1:0] row [NIB_W];

   genvar gi;
   generate
      for (gi = 0; gi < NIB_W; gi++) begin : g_row
         assign row[gi] = b[gi] ? ({{NIB_W{1'b0}}, a} << gi) : '0;
      end
   endgenerate

   always_comb begin
      p = '0;
      for (int i = 0; i < NIB_W; i++) begin
         p = p + row[i];
      end
   end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier: one 4x4 array multiplier time-shared over
// four MUL steps. Define MULT8_ZERO_SKIP_EN to let zero operands bypass MUL.
module mult8_seq_ctrl
   import mult_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] product,
   output logic              busy
);

   state_t              state_q, state_d;
   logic [OPND_W-1:0]   a_q, a_d;
   logic [OPND_W-1:0]   b_q, b_d;
   logic [PROD_W-1:0]   acc_q, acc_d;
   logic [STEP_W-1:0]   step_q, step_d;

   logic [NIB_W-1:0]    a_nib;
   logic [NIB_W-1:0]    b_nib;
   logic [2*NIB_W-1:0]  pp;
   logic [PROD_W-1:0]   pp_placed;

   assign a_nib = step_q[0] ? a_q[OPND_W-1:NIB_W] : a_q[NIB_W-1:0];
   assign b_nib = step_q[1] ? b_q[OPND_W-1:NIB_W] : b_q[NIB_W-1:0];

   mult4x4_array u_mult4x4 (
      .a (a_nib),
      .b (b_nib),
      .p (pp)
   );

   assign pp_placed = place_partial(pp, step_q);

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      step_d    = step_q;
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               acc_d   = '0;
               step_d  = '0;
               state_d = MUL;
`ifdef MULT8_ZERO_SKIP_EN
               if ((a == '0) || (b == '0)) begin
                  state_d = DONE;
               end
`endif
            end
         end
         MUL: begin
            // The sum of partial products is at most 0xFE01, so this add never wraps.
            acc_d  = acc_q + pp_placed;
            step_d = step_q + 1'b1;
            if (step_q == STEP_W'(STEPS - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         step_q  <= step_d;
      end
   end

   // The accumulator doubles as the output register and keeps the last result.
   assign product = acc_q;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Self-checking bench for mult8_seq_ctrl: directed scenarios plus a random
// back-to-back run, all checked against a queue of expected products.
module tb_mult8_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic        busy;

   int          n_vec;
   int          n_err;
   logic [15:0] exp_q[$];

`ifdef MULT8_ZERO_SKIP_EN
   localparam int ZERO_LAT = 1;
`else
   localparam int ZERO_LAT = 5;
`endif

   mult8_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one operand pair for a single cycle; push the expected product if taken.
   task automatic do_accept(input logic [7:0] av, input logic [7:0] bv, output logic took);
      @(posedge clk) #1;
      in_valid = 1'b1;
      a        = av;
      b        = bv;
      @(negedge clk);
      took = in_ready;
      if (took) exp_q.push_back(16'(av) * 16'(bv));
      @(posedge clk) #1;
      in_valid = 1'b0;
   endtask

   // Count negedges after the accept edge until out_valid; 0 means it never came.
   task automatic wait_out(output int cyc);
      cyc = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (out_valid) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic pop_exp(output logic [15:0] e);
      if (exp_q.size() == 0) begin
         e = 16'hxxxx;
      end else begin
         e = exp_q.pop_front();
      end
   endtask

   task automatic out_handshake();
      @(posedge clk) #1;
      out_ready = 1'b1;
      @(posedge clk) #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; a = 8'h03; b = 8'h03; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      n_vec++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_vec++;
      if (product !== 16'h0000) begin n_err++; $display("FAIL reset_product got=%h want=0000", product); end
      $display("txn reset: in_ready=%b out_valid=%b busy=%b product=%h", in_ready, out_valid, busy, product);
   endtask

   task automatic test_max();
      logic        took;
      int          cyc;
      logic [15:0] e;
      do_accept(8'hFF, 8'hFF, took);
      n_vec++;
      if (took !== 1'b1) begin n_err++; $display("FAIL max_accept got=%b want=1", took); end
      wait_out(cyc);
      n_vec++;
      if (cyc != 5) begin n_err++; $display("FAIL max_latency got=%0d want=5", cyc); end
      pop_exp(e);
      n_vec++;
      if (product !== e) begin n_err++; $display("FAIL max_product got=%h want=%h", product, e); end
      n_vec++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL max_busy got=%b want=1", busy); end
      $display("txn max: a=ff b=ff product=%h latency=%0d", product, cyc);
      out_handshake();
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL max_return_idle got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
      n_vec++;
      if (product !== e) begin n_err++; $display("FAIL max_product_kept got=%h want=%h", product, e); end
   endtask

   task automatic test_hold();
      logic        took;
      int          cyc;
      logic [15:0] e;
      logic        bad;
      do_accept(8'h12, 8'h34, took);
      n_vec++;
      if (took !== 1'b1) begin n_err++; $display("FAIL hold_accept got=%b want=1", took); end
      wait_out(cyc);
      pop_exp(e);
      @(posedge clk) #1;
      in_valid = 1'b1; a = 8'hAA; b = 8'h55;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== e) begin
            bad = 1'b1;
            $display("FAIL hold_cycle%0d got out_valid=%b in_ready=%b product=%h want 1/0/%h",
                     i, out_valid, in_ready, product, e);
         end
      end
      n_vec++;
      if (bad) n_err++;
      @(posedge clk) #1;
      in_valid = 1'b0;
      $display("txn hold: a=12 b=34 product=%h held 10 cycles", product);
      out_handshake();
   endtask

   task automatic test_ignore();
      logic        took;
      int          cyc;
      logic [15:0] e;
      logic        saw;
      do_accept(8'h5A, 8'hC3, took);
      n_vec++;
      if (took !== 1'b1) begin n_err++; $display("FAIL ignore_accept got=%b want=1", took); end
      in_valid = 1'b1; a = 8'h01; b = 8'h01;
      @(posedge clk) #1;
      in_valid = 1'b0;
      wait_out(cyc);
      n_vec++;
      if (cyc == 0) begin n_err++; $display("FAIL ignore_timeout got=no out_valid want=out_valid"); end
      pop_exp(e);
      n_vec++;
      if (product !== e) begin n_err++; $display("FAIL ignore_product got=%h want=%h", product, e); end
      $display("txn ignore: a=5a b=c3 product=%h", product);
      out_handshake();
      saw = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || in_ready !== 1'b1) saw = 1'b1;
      end
      n_vec++;
      if (saw) begin n_err++; $display("FAIL ignore_second_op got=extra activity want=idle"); end
   endtask

   task automatic test_abort();
      logic took;
      logic saw;
      do_accept(8'h80, 8'h80, took);
      n_vec++;
      if (took !== 1'b1) begin n_err++; $display("FAIL abort_accept got=%b want=1", took); end
      exp_q.delete();
      rst = 1'b1;
      @(posedge clk) #1;
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++; $display("FAIL abort_flags got in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
      end
      n_vec++;
      if (product !== 16'h0000) begin n_err++; $display("FAIL abort_product got=%h want=0000", product); end
      saw = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) saw = 1'b1;
      end
      n_vec++;
      if (saw) begin n_err++; $display("FAIL abort_stale got=out_valid seen want=none"); end
      $display("txn abort: a=80 b=80 reset mid-MUL, product=%h", product);
   endtask

   task automatic test_zero();
      logic [7:0]  za[2];
      logic [7:0]  zb[2];
      logic        took;
      int          cyc;
      logic [15:0] e;
      za[0] = 8'h00; zb[0] = 8'h5A;
      za[1] = 8'h37; zb[1] = 8'h00;
      for (int t = 0; t < 2; t++) begin
         do_accept(za[t], zb[t], took);
         wait_out(cyc);
         n_vec++;
         if (cyc != ZERO_LAT) begin n_err++; $display("FAIL zero%0d_latency got=%0d want=%0d", t, cyc, ZERO_LAT); end
         pop_exp(e);
         n_vec++;
         if (product !== e) begin n_err++; $display("FAIL zero%0d_product got=%h want=%h", t, product, e); end
         $display("txn zero: a=%h b=%h product=%h latency=%0d", za[t], zb[t], product, cyc);
         out_handshake();
      end
   endtask

   task automatic test_back_to_back();
      int          n_acc;
      int          n_out;
      logic        taken;
      logic [15:0] e;
      n_acc = 0; n_out = 0; taken = 1'b0;
      exp_q.delete();
      for (int cyc = 0; cyc < 20000 && n_out < 200; cyc++) begin
         @(posedge clk) #1;
         if (taken) in_valid = 1'b0;
         taken = 1'b0;
         if (!in_valid && n_acc < 200 && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            a = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
         end
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (in_valid && in_ready) begin
            exp_q.push_back(16'(a) * 16'(b));
            n_acc++;
            taken = 1'b1;
         end
         if (out_valid && out_ready) begin
            pop_exp(e);
            n_vec++;
            if (product !== e) begin n_err++; $display("FAIL b2b_txn%0d got=%h want=%h", n_out, product, e); end
            $display("txn b2b %0d: product=%h", n_out, product);
            n_out++;
         end
      end
      @(posedge clk) #1;
      in_valid = 1'b0; out_ready = 1'b0;
      n_vec++;
      if (n_out != 200 || exp_q.size() != 0) begin
         n_err++; $display("FAIL b2b_count got=%0d outputs, %0d pending want=200, 0", n_out, exp_q.size());
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
      test_reset();
      test_max();
      test_hold();
      test_ignore();
      test_abort();
      test_zero();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
